// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes, the ram2axi FSM state
// type and a worst-response helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W_FETCH,
    ST_W_DATA,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } ram2axi_state_e;

  // Encodings are ordered by severity, so the numerically larger code is worse.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle with master (m) and slave (s) views.
// Handshake: a beat transfers on a rising clk edge where VALID and READY are both 1.
interface axi_if #(
  parameter int ID_W_WIDTH  = 4,
  parameter int ID_R_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_WIDTH  = 8,
  parameter int BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH
);
  logic [ID_W_WIDTH-1:0]  awid;
  logic [ADDR_WIDTH-1:0]  awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [BATCH_WIDTH-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [ID_W_WIDTH-1:0]  bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ID_R_WIDTH-1:0]  arid;
  logic [ADDR_WIDTH-1:0]  araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [ID_R_WIDTH-1:0]  rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ram2axi_pmu.sv
// Saturating stall/idle counter bank for ram2axi; clear has priority over counting.
module ram2axi_pmu (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        aw_stall,
  input  logic        w_stall,
  input  logic        ar_stall,
  input  logic        r_idle,
  output logic [31:0] pmu_aw_stall,
  output logic [31:0] pmu_w_stall,
  output logic [31:0] pmu_ar_stall,
  output logic [31:0] pmu_r_idle
);
  logic [3:0]  ev;
  logic [31:0] cnt [4];

  assign ev = {r_idle, ar_stall, w_stall, aw_stall};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clear) cnt[i] <= '0;
      else if (ev[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 32'd1;
    end
  end

  assign pmu_aw_stall = cnt[0];
  assign pmu_w_stall  = cnt[1];
  assign pmu_ar_stall = cnt[2];
  assign pmu_r_idle   = cnt[3];
endmodule

// File: rtl/ram2axi.sv
// Command-driven AXI4 master moving one INCR burst between local RAM and AXI.
// Optional counter bank enabled by macro RAM2AXI_PMU_EN.
module ram2axi
  import axi_pkg::*;
#(
  parameter int ID_W_WIDTH  = 4,
  parameter int ID_R_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_WIDTH  = 8,
  parameter int BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [((ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH)-1:0] cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_axi_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_ram_addr,
  input  logic [7:0]            cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
`ifdef RAM2AXI_PMU_EN
  input  logic                  pmu_clear,
  output logic [31:0]           pmu_aw_stall,
  output logic [31:0]           pmu_w_stall,
  output logic [31:0]           pmu_ar_stall,
  output logic [31:0]           pmu_r_idle,
`endif
  output logic [2:0]            dbg_state,
  axi_if.m                      axi_m
);
  localparam int ID_WIDTH = (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH;

  ram2axi_state_e        state_q, state_d;
  logic                  write_q, write_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] axi_addr_q, axi_addr_d;
  logic [ADDR_WIDTH-1:0] ram_ptr_q, ram_ptr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            resp_q, resp_d;
  logic                  idle_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic                  last_beat;

  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      id_q       <= '0;
      axi_addr_q <= '0;
      ram_ptr_q  <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      id_q       <= id_d;
      axi_addr_q <= axi_addr_d;
      ram_ptr_q  <= ram_ptr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      resp_q     <= resp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    id_d       = id_q;
    axi_addr_d = axi_addr_q;
    ram_ptr_d  = ram_ptr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    resp_d     = resp_q;
    idle_ready = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    ram_we     = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (cmd_valid) begin
          write_d    = cmd_write;
          id_d       = cmd_id;
          axi_addr_d = cmd_axi_addr;
          ram_ptr_d  = cmd_ram_addr;
          len_d      = cmd_len;
          beat_d     = '0;
          resp_d     = RESP_OKAY;
          state_d    = cmd_write ? ST_AW : ST_AR;
        end
      end
      ST_AW: begin
        aw_valid = 1'b1;
        if (axi_m.awready) state_d = ST_W_FETCH;
      end
      ST_W_FETCH: state_d = ST_W_DATA;
      ST_W_DATA: begin
        w_valid = 1'b1;
        if (axi_m.wready) begin
          ram_ptr_d = ram_ptr_q + ADDR_WIDTH'(1);
          beat_d    = beat_q + 8'd1;
          state_d   = last_beat ? ST_B : ST_W_FETCH;
        end
      end
      ST_B: begin
        b_ready = 1'b1;
        if (axi_m.bvalid) begin
          resp_d  = axi_m.bresp;
          state_d = ST_DONE;
        end
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (axi_m.arready) state_d = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (axi_m.rvalid) begin
          ram_we    = 1'b1;
          ram_ptr_d = ram_ptr_q + ADDR_WIDTH'(1);
          beat_d    = beat_q + 8'd1;
          resp_d    = resp_max(resp_q, axi_m.rresp);
          // A burst whose RLAST disagrees with the requested length is a slave error.
          if (axi_m.rlast != last_beat) resp_d = resp_max(resp_d, RESP_SLVERR);
          if (axi_m.rlast || last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = idle_ready & ~rst;
  assign ram_addr   = ram_ptr_q;
  assign ram_wdata  = axi_m.rdata;
  assign done_write = write_q;
  assign done_resp  = resp_q;
  assign dbg_state  = state_q;

  assign axi_m.awid    = id_q[ID_W_WIDTH-1:0];
  assign axi_m.awaddr  = axi_addr_q;
  assign axi_m.awlen   = len_q;
  assign axi_m.awsize  = 3'($clog2(BATCH_WIDTH));
  assign axi_m.awburst = BURST_INCR;
  assign axi_m.awvalid = aw_valid;
  assign axi_m.wdata   = ram_rdata;
  assign axi_m.wstrb   = '1;
  assign axi_m.wlast   = last_beat;
  assign axi_m.wvalid  = w_valid;
  assign axi_m.bready  = b_ready;
  assign axi_m.arid    = id_q[ID_R_WIDTH-1:0];
  assign axi_m.araddr  = axi_addr_q;
  assign axi_m.arlen   = len_q;
  assign axi_m.arsize  = 3'($clog2(BATCH_WIDTH));
  assign axi_m.arburst = BURST_INCR;
  assign axi_m.arvalid = ar_valid;
  assign axi_m.rready  = r_ready;

`ifdef RAM2AXI_PMU_EN
  ram2axi_pmu u_pmu (
    .clk          (clk),
    .rst          (rst),
    .clear        (pmu_clear),
    .aw_stall     (aw_valid & ~axi_m.awready),
    .w_stall      (w_valid & ~axi_m.wready),
    .ar_stall     (ar_valid & ~axi_m.arready),
    .r_idle       ((state_q == ST_R) & ~axi_m.rvalid),
    .pmu_aw_stall (pmu_aw_stall),
    .pmu_w_stall  (pmu_w_stall),
    .pmu_ar_stall (pmu_ar_stall),
    .pmu_r_idle   (pmu_r_idle)
  );
`endif
endmodule

// File: tb/tb_ram2axi.sv
// Directed bench for ram2axi: a local RAM model and a procedural AXI slave,
// with every expectation written out by hand.
module tb_ram2axi;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_id;
  logic [15:0] cmd_axi_addr;
  logic [15:0] cmd_ram_addr;
  logic [7:0]  cmd_len;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        done_valid;
  logic        done_write;
  logic [1:0]  done_resp;
  logic [2:0]  dbg_state;
`ifdef RAM2AXI_PMU_EN
  logic        pmu_clear;
  logic [31:0] pmu_aw_stall, pmu_w_stall, pmu_ar_stall, pmu_r_idle;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) axi ();

  ram2axi #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_id       (cmd_id),
    .cmd_axi_addr (cmd_axi_addr),
    .cmd_ram_addr (cmd_ram_addr),
    .cmd_len      (cmd_len),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .done_valid   (done_valid),
    .done_write   (done_write),
    .done_resp    (done_resp),
`ifdef RAM2AXI_PMU_EN
    .pmu_clear    (pmu_clear),
    .pmu_aw_stall (pmu_aw_stall),
    .pmu_w_stall  (pmu_w_stall),
    .pmu_ar_stall (pmu_ar_stall),
    .pmu_r_idle   (pmu_r_idle),
`endif
    .dbg_state    (dbg_state),
    .axi_m        (axi)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Synchronous RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return axi.awvalid;
      1: return axi.wvalid;
      2: return axi.arvalid;
      3: return axi.bready;
      4: return axi.rready;
      5: return done_valid;
      default: return cmd_ready;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel);
    int n = 0;
    while (!probe(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n < 100, 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] addr, input logic [31:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [15:0] aaddr,
                          input logic [15:0] raddr, input logic [7:0] len);
    cmd_write = wr; cmd_id = id; cmd_axi_addr = aaddr; cmd_ram_addr = raddr; cmd_len = len;
    cmd_valid = 1'b1;
    wait_for("cmd_ready", 6);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_aw(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id);
    axi.awready = 1'b1;
    wait_for("awvalid", 0);
    check("awaddr", axi.awaddr, addr);
    check("awlen", axi.awlen, len);
    check("awid", axi.awid, id);
    check("awburst", axi.awburst, 2'b01);
    check("awsize", axi.awsize, 3'd2);
    @(negedge clk);
  endtask

  task automatic expect_w(input logic [31:0] data, input logic last, input int stall);
    axi.wready = (stall == 0);
    wait_for("wvalid", 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("w_hold_valid", axi.wvalid, 1'b1);
      check("w_hold_data", axi.wdata, data);
    end
    check("wdata", axi.wdata, data);
    check("wlast", axi.wlast, last);
    check("wstrb", axi.wstrb, 4'hf);
    axi.wready = 1'b1;
    @(negedge clk);
    axi.wready = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] resp);
    wait_for("bready", 3);
    axi.bvalid = 1'b1; axi.bresp = resp;
    @(negedge clk);
    axi.bvalid = 1'b0;
  endtask

  task automatic expect_ar(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id);
    axi.arready = 1'b1;
    wait_for("arvalid", 2);
    check("araddr", axi.araddr, addr);
    check("arlen", axi.arlen, len);
    check("arid", axi.arid, id);
    check("arburst", axi.arburst, 2'b01);
    @(negedge clk);
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp; axi.rlast = last;
    wait_for("rready", 4);
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
  endtask

  task automatic wait_done(input logic wr, input logic [1:0] resp);
    wait_for("done_valid", 5);
    check("done_write", done_write, wr);
    check("done_resp", done_resp, resp);
    @(negedge clk);
    check("done_one_pulse", done_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0;
    cmd_axi_addr = '0; cmd_ram_addr = '0; cmd_len = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef RAM2AXI_PMU_EN
    pmu_clear = 1'b0;
`endif
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = '0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_done_resp", done_resp, 2'b00);
    check("rst_ram_we", ram_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) preload(8'h20 + 8'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) preload(8'h70 + 8'(i), 32'h700 + 32'(i));
    preload(8'h30, 32'h1234_5678);
    preload(8'h31, 32'h9ABC_DEF0);
    preload(8'h62, 32'hDEAD_BEEF);

    // Write len=3, always-ready slave.
    send_cmd(1'b1, 4'h3, 16'h0010, 16'h0020, 8'd3);
    expect_aw(16'h0010, 8'd3, 4'h3);
    for (int i = 0; i < 4; i++) expect_w(32'hA0 + 32'(i), i == 3, 0);
    do_b(2'b00);
    wait_done(1'b1, 2'b00);

    // Read len=3 into RAM 0x40.
    send_cmd(1'b0, 4'h5, 16'h0010, 16'h0040, 8'd3);
    expect_ar(16'h0010, 8'd3, 4'h5);
    for (int i = 0; i < 4; i++) r_beat(32'hA0 + 32'(i), 2'b00, i == 3);
    wait_done(1'b0, 2'b00);
    for (int i = 0; i < 4; i++) check("rd_mem", mem[8'h40 + 8'(i)], 32'hA0 + 32'(i));

    // Single-beat write with 5 cycles of WREADY backpressure.
    send_cmd(1'b1, 4'h1, 16'h0080, 16'h0020, 8'd0);
    expect_aw(16'h0080, 8'd0, 4'h1);
    expect_w(32'hA0, 1'b1, 5);
    do_b(2'b00);
    wait_done(1'b1, 2'b00);
`ifdef RAM2AXI_PMU_EN
    check("pmu_w_stall_len0", pmu_w_stall, 32'd5);
    check("pmu_aw_stall", pmu_aw_stall, 32'd0);
`endif

    // Read with SLVERR on beat 2 of 4.
    send_cmd(1'b0, 4'h2, 16'h0100, 16'h0050, 8'd3);
    expect_ar(16'h0100, 8'd3, 4'h2);
    for (int i = 0; i < 4; i++) r_beat(32'hB0 + 32'(i), (i == 1) ? 2'b10 : 2'b00, i == 3);
    wait_done(1'b0, 2'b10);
    for (int i = 0; i < 4; i++) check("slverr_mem", mem[8'h50 + 8'(i)], 32'hB0 + 32'(i));

    // Read len=3 where the slave ends the burst early on beat 2.
    send_cmd(1'b0, 4'h4, 16'h0200, 16'h0060, 8'd3);
    expect_ar(16'h0200, 8'd3, 4'h4);
    r_beat(32'hC0, 2'b00, 1'b0);
    r_beat(32'hC1, 2'b00, 1'b1);
    wait_done(1'b0, 2'b10);
    check("early_mem0", mem[8'h60], 32'hC0);
    check("early_mem1", mem[8'h61], 32'hC1);
    check("early_mem2_untouched", mem[8'h62], 32'hDEAD_BEEF);

    // Reset during W_DATA of a len=7 write, after 3 stalled cycles.
`ifdef RAM2AXI_PMU_EN
    pmu_clear = 1'b1;
    @(negedge clk);
    pmu_clear = 1'b0;
`endif
    send_cmd(1'b1, 4'h7, 16'h0300, 16'h0070, 8'd7);
    expect_aw(16'h0300, 8'd7, 4'h7);
    axi.wready = 1'b0;
    wait_for("wvalid_rst", 1);
    repeat (3) @(negedge clk);
    check("rst_pre_wdata", axi.wdata, 32'h700);
`ifdef RAM2AXI_PMU_EN
    check("pmu_w_stall_rst", pmu_w_stall, 32'd3);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_awvalid", axi.awvalid, 1'b0);
    check("mid_rst_wvalid", axi.wvalid, 1'b0);
    check("mid_rst_arvalid", axi.arvalid, 1'b0);
    check("mid_rst_bready", axi.bready, 1'b0);
    check("mid_rst_rready", axi.rready, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check("mid_rst_done", done_valid, 1'b0);
    @(negedge clk);
    check("mid_rst_cmd_ready2", cmd_ready, 1'b0);
    check("mid_rst_done2", done_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    check("post_rst_done", done_valid, 1'b0);

    // Fresh command after reset.
    send_cmd(1'b1, 4'h6, 16'h0090, 16'h0030, 8'd1);
    expect_aw(16'h0090, 8'd1, 4'h6);
    expect_w(32'h1234_5678, 1'b0, 0);
    expect_w(32'h9ABC_DEF0, 1'b1, 0);
    do_b(2'b00);
    wait_done(1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
